// File: rtl/ps2_scan_rx.sv
// rtl/ps2_scan_rx.sv - PS/2 device-to-host frame receiver with break-prefix stripping
// Filters ps2_clk, deserialises 11-bit frames and presents scan codes as byte plus held nibbles.
module ps2_scan_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       break_flag,
  output logic       frame_err,
  output logic [3:0] hex_hi,
  output logic [3:0] hex_lo
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {S_IDLE, S_RECV} state_t;

  state_t                r_state;
  state_t                w_state_nx;
  logic                  r_clk_s1, r_clk_s2;
  logic                  r_data_s1, r_data_s2;
  logic [FILTER_LEN-1:0] r_clk_sr;
  logic                  r_filt;
  logic [3:0]            r_bit_cnt;
  logic [TW-1:0]         r_to_cnt;
  logic [8:0]            r_shift;
  logic                  r_pend_break;
  logic [7:0]            r_scan_code;
  logic                  r_code_valid;
  logic                  r_break_flag;
  logic                  r_frame_err;
  logic [3:0]            r_hex_hi, r_hex_lo;

  logic w_all0, w_all1, w_fall;
  logic w_start, w_stop_eval, w_timeout, w_good;

  // Sync flops idle high so reset never manufactures a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1  <= 1'b1;
      r_clk_s2  <= 1'b1;
      r_data_s1 <= 1'b1;
      r_data_s2 <= 1'b1;
      r_clk_sr  <= '1;
      r_filt    <= 1'b1;
    end else begin
      r_clk_s1  <= ps2_clk;
      r_clk_s2  <= r_clk_s1;
      r_data_s1 <= ps2_data;
      r_data_s2 <= r_data_s1;
      r_clk_sr  <= {r_clk_sr[FILTER_LEN-2:0], r_clk_s2};
      if (w_all0)
        r_filt <= 1'b0;
      else if (w_all1)
        r_filt <= 1'b1;
    end
  end

  assign w_all0 = (r_clk_sr == '0);
  assign w_all1 = &r_clk_sr;
  assign w_fall = r_filt & w_all0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nx;
  end

  // A stop-bit fall takes priority over the timeout terminal count.
  always_comb begin
    w_state_nx  = r_state;
    w_start     = 1'b0;
    w_stop_eval = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall && !r_data_s2) begin
          w_start    = 1'b1;
          w_state_nx = S_RECV;
        end
      end
      S_RECV: begin
        if (w_fall) begin
          if (r_bit_cnt == 4'd9) begin
            w_stop_eval = 1'b1;
            w_state_nx  = S_IDLE;
          end
        end else if (r_to_cnt == TO_LAST) begin
          w_timeout  = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // r_shift holds data bits [7:0] and parity in [8] once bit 8 has been shifted in.
  assign w_good = w_stop_eval & (^r_shift) & r_data_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_to_cnt  <= '0;
      r_shift   <= '0;
    end else if (w_start) begin
      r_bit_cnt <= '0;
      r_to_cnt  <= '0;
    end else if (r_state == S_RECV) begin
      if (w_fall) begin
        r_to_cnt  <= '0;
        r_bit_cnt <= r_bit_cnt + 4'd1;
        if (r_bit_cnt < 4'd9)
          r_shift <= {r_data_s2, r_shift[8:1]};
      end else begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_break <= 1'b0;
      r_scan_code  <= '0;
      r_code_valid <= 1'b0;
      r_break_flag <= 1'b0;
      r_frame_err  <= 1'b0;
      r_hex_hi     <= '0;
      r_hex_lo     <= '0;
    end else begin
      r_code_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_timeout || (w_stop_eval && !w_good)) begin
        r_frame_err  <= 1'b1;
        r_pend_break <= 1'b0;
      end else if (w_good) begin
        if (r_shift[7:0] == 8'hF0) begin
          r_pend_break <= 1'b1;
        end else begin
          r_scan_code  <= r_shift[7:0];
          r_hex_hi     <= r_shift[7:4];
          r_hex_lo     <= r_shift[3:0];
          r_code_valid <= 1'b1;
          r_break_flag <= r_pend_break;
          r_pend_break <= 1'b0;
        end
      end
    end
  end

  assign scan_code  = r_scan_code;
  assign code_valid = r_code_valid;
  assign break_flag = r_break_flag;
  assign frame_err  = r_frame_err;
  assign hex_hi     = r_hex_hi;
  assign hex_lo     = r_hex_lo;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// tb/tb_ps2_scan_rx.sv - directed and randomized checks of ps2_scan_rx against a frame-level model
// The model decides each frame's outcome from byte, parity and stop values alone.
module tb_ps2_scan_rx;

  localparam int FL  = 4;
  localparam int TO  = 200;
  localparam int LAT = 2 + FL + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic       code_valid, break_flag, frame_err;
  logic [3:0] hex_hi, hex_lo;

  int checks = 0;
  int errors = 0;
  int cv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;

  logic [7:0] m_scan = 8'h00;
  logic       m_brk  = 1'b0;
  logic       m_pend = 1'b0;

  ps2_scan_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .scan_code(scan_code), .code_valid(code_valid), .break_flag(break_flag),
    .frame_err(frame_err), .hex_hi(hex_hi), .hex_lo(hex_lo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (code_valid) cv_cnt++;
    if (frame_err) fe_cnt++;
    if (code_valid && frame_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits, input int h,
                           input bit glitch, output int lat);
    lat = -1;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (glitch) begin
        repeat (h / 2) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (h - h / 2 - 2) @(negedge clk);
      end else begin
        repeat (h) @(negedge clk);
      end
      ps2_clk = 1'b0;
      if (i == 10) begin
        for (int k = 1; k <= h; k++) begin
          @(posedge clk);
          #1;
          if (lat < 0 && (code_valid || frame_err)) lat = k;
        end
        @(negedge clk);
      end else begin
        repeat (h) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".scan"}, 32'(scan_code), 32'(m_scan));
    check({tag, ".hex_hi"}, 32'(hex_hi), 32'(m_scan[7:4]));
    check({tag, ".hex_lo"}, 32'(hex_lo), 32'(m_scan[3:0]));
    check({tag, ".brk"}, 32'(break_flag), 32'(m_brk));
  endtask

  task automatic do_frame(input string tag, input logic [7:0] b, input logic par,
                          input logic stp, input int h, input bit glitch);
    int  cv0, fe0, lat, ones;
    bit  good, ecv, efe;
    cv0  = cv_cnt;
    fe0  = fe_cnt;
    ones = $countones(b) + int'(par);
    good = stp && (ones % 2 == 1);
    ecv  = 1'b0;
    efe  = 1'b0;
    if (!good) begin
      efe    = 1'b1;
      m_pend = 1'b0;
    end else if (b == 8'hF0) begin
      m_pend = 1'b1;
    end else begin
      ecv    = 1'b1;
      m_scan = b;
      m_brk  = m_pend;
      m_pend = 1'b0;
    end
    send_bits({stp, par, b, 1'b0}, 11, h, glitch, lat);
    repeat (5) @(negedge clk);
    check({tag, ".cv"}, 32'(cv_cnt - cv0), 32'(ecv));
    check({tag, ".fe"}, 32'(fe_cnt - fe0), 32'(efe));
    check_outputs(tag);
    if (ecv || efe) check({tag, ".lat"}, 32'(lat), 32'(LAT));
  endtask

  function automatic logic odd_par(input logic [7:0] b);
    return ~(^b);
  endfunction

  initial begin : stim
    int cv0, fe0, lat, h;
    logic [7:0] b;
    logic par, stp;

    repeat (3) @(negedge clk);
    check_outputs("reset");
    check("reset.cv", 32'(code_valid), 32'h0);
    check("reset.fe", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    do_frame("make_1c", 8'h1C, 1'b0, 1'b1, 20, 1'b0);
    do_frame("brk_f0", 8'hF0, odd_par(8'hF0), 1'b1, 20, 1'b0);
    do_frame("brk_1c", 8'h1C, 1'b0, 1'b1, 20, 1'b0);
    do_frame("make_32", 8'h32, odd_par(8'h32), 1'b1, 20, 1'b0);
    do_frame("make_1c_b", 8'h1C, 1'b0, 1'b1, 20, 1'b0);
    do_frame("bad_par", 8'h1C, 1'b1, 1'b1, 20, 1'b0);
    do_frame("bad_stop", 8'h1C, 1'b0, 1'b0, 20, 1'b0);

    // Start bit plus five data bits, then silence past the timeout.
    cv0 = cv_cnt;
    fe0 = fe_cnt;
    send_bits({2'b11, 8'h1C, 1'b0}, 6, 20, 1'b0, lat);
    repeat (TO + 100) @(negedge clk);
    m_pend = 1'b0;
    check("timeout.fe", 32'(fe_cnt - fe0), 32'h1);
    check("timeout.cv", 32'(cv_cnt - cv0), 32'h0);
    do_frame("after_to", 8'h32, odd_par(8'h32), 1'b1, 20, 1'b0);

    cv0 = cv_cnt;
    fe0 = fe_cnt;
    for (int g = 0; g < 4; g++) begin
      ps2_clk = 1'b0;
      repeat (2) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check("glitch_idle.cv", 32'(cv_cnt - cv0), 32'h0);
    check("glitch_idle.fe", 32'(fe_cnt - fe0), 32'h0);
    do_frame("glitch_45", 8'h45, odd_par(8'h45), 1'b1, 20, 1'b1);

    // Reset after data bit 4 of a frame.
    send_bits({2'b11, 8'h2A, 1'b0}, 6, 20, 1'b0, lat);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_scan = 8'h00;
    m_brk  = 1'b0;
    m_pend = 1'b0;
    check_outputs("midreset");
    check("midreset.cv", 32'(code_valid), 32'h0);
    check("midreset.fe", 32'(frame_err), 32'h0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    do_frame("post_reset", 8'h1C, 1'b0, 1'b1, 20, 1'b0);

    for (int r = 0; r < 12; r++) begin
      b   = ($urandom_range(0, 3) == 0) ? 8'hF0 : 8'($urandom);
      par = ($urandom_range(0, 4) == 0) ? ~odd_par(b) : odd_par(b);
      stp = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
      h   = $urandom_range(15, 25);
      do_frame($sformatf("rand%0d", r), b, par, stp, h, 1'($urandom_range(0, 1)));
    end

    check("excl", 32'(both_cnt), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
